// File: rtl/pa_risc_fetch_unit_if.sv
// Fetch-stage bundle: control inputs, instruction-ROM port and IF/ID outputs.
// Ports: LE/hz_stall/br_taken/br_target in, imem_addr out / imem_data in,
//        PC pair, IF/ID instruction, PC, valid and fetch counter out.
interface pa_risc_fetch_unit_if #(
    parameter int IMEM_AW = 9
);
    logic               LE;
    logic               hz_stall;
    logic               br_taken;
    logic [31:0]        br_target;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic [31:0]        PCFrontOut;
    logic [31:0]        PCBackOut;
    logic [31:0]        InstructionOut;
    logic [31:0]        if_id_pc;
    logic               if_id_valid;
    logic [31:0]        fetch_count;

    // master: the fetch unit itself
    modport master (
        input  LE, hz_stall, br_taken, br_target, imem_data,
        output imem_addr, PCFrontOut, PCBackOut, InstructionOut,
               if_id_pc, if_id_valid, fetch_count
    );

    // slave: pipeline control, EX stage and instruction ROM around it
    modport slave (
        output LE, hz_stall, br_taken, br_target, imem_data,
        input  imem_addr, PCFrontOut, PCBackOut, InstructionOut,
               if_id_pc, if_id_valid, fetch_count
    );
endinterface

// File: rtl/pa_risc_fetch_unit.sv
// Purpose: PA-RISC IF stage: front/back PC pair, ROM address, IF/ID register.
// Latency: word at imem_addr appears on InstructionOut one clock edge later.
// Backpressure: LE=0 freezes everything; hz_stall holds PC pair and IF/ID.
// Ports: clk, reset (async active-high), fif (master side of the fetch bundle:
//        control in, ROM address/data, PC pair, IF/ID instr/pc/valid, count).
module pa_risc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 9,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    pa_risc_fetch_unit_if.master fif
);
    logic [31:0] pc_front_q, pc_front_d;
    logic [31:0] pc_back_q,  pc_back_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] id_pc_q,    id_pc_d;
    logic        id_vld_q,   id_vld_d;
    logic [31:0] count_q,    count_d;
    logic [31:0] tgt_word;

    // Targets are forced word-aligned; low bits are simply dropped.
    assign tgt_word = fif.br_target & ~32'd3;

    always_comb begin
        pc_front_d = pc_front_q;
        pc_back_d  = pc_back_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_vld_d   = id_vld_q;
        count_d    = count_q;
        if (fif.LE) begin
            if (fif.br_taken) begin
                pc_front_d = tgt_word;
                pc_back_d  = tgt_word + 32'd4;
                // The word now in IF follows the delay slot and is squashed.
                // Under a stall the delay slot is still in IF/ID, so keep it.
                if (!fif.hz_stall) begin
                    instr_d  = NOP_WORD;
                    id_vld_d = 1'b0;
                end
            end else if (!fif.hz_stall) begin
                instr_d    = fif.imem_data;
                id_pc_d    = pc_front_q;
                id_vld_d   = 1'b1;
                pc_front_d = pc_back_q;
                pc_back_d  = pc_back_q + 32'd4;
                count_d    = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_front_q <= RESET_PC;
            pc_back_q  <= RESET_PC + 32'd4;
            instr_q    <= NOP_WORD;
            id_pc_q    <= 32'd0;
            id_vld_q   <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            pc_front_q <= pc_front_d;
            pc_back_q  <= pc_back_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_vld_q   <= id_vld_d;
            count_q    <= count_d;
        end
    end

    assign fif.imem_addr      = pc_front_q[IMEM_AW-1:0];
    assign fif.PCFrontOut     = pc_front_q;
    assign fif.PCBackOut      = pc_back_q;
    assign fif.InstructionOut = instr_q;
    assign fif.if_id_pc       = id_pc_q;
    assign fif.if_id_valid    = id_vld_q;
    assign fif.fetch_count    = count_q;
endmodule

// File: tb/tb_pa_risc_fetch_unit.sv
module tb_pa_risc_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] front;
        logic [31:0] back;
        logic [31:0] cnt;
        logic        vld;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] rom [0:127];
    obs_t sb [$];
    int n_cmp = 0;
    int n_bad = 0;

    pa_risc_fetch_unit_if #(.IMEM_AW(9)) fif ();

    pa_risc_fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(9), .NOP_WORD(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    always #5 clk = ~clk;
    assign fif.imem_data = rom[fif.imem_addr[8:2]];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        obs_t o;
        o.instr = fif.InstructionOut;
        o.pc    = fif.if_id_pc;
        o.front = fif.PCFrontOut;
        o.back  = fif.PCBackOut;
        o.cnt   = fif.fetch_count;
        o.vld   = fif.if_id_valid;
        return o;
    endfunction

    function automatic obs_t mk(logic [31:0] i, logic [31:0] p, logic [31:0] f,
                                logic [31:0] b, logic [31:0] c, logic v);
        obs_t o;
        o.instr = i; o.pc = p; o.front = f; o.back = b; o.cnt = c; o.vld = v;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fif.LE = 1'b1; fif.hz_stall = 1'b0; fif.br_taken = 1'b0; fif.br_target = 32'h0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        fif.LE = 1'b1; fif.hz_stall = 1'b0; fif.br_taken = 1'b0; fif.br_target = 32'h0;
        reset = 1'b1;
        #12;
        sb.push_back(mk(NOP, 0, 0, 4, 0, 0));
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_held got %h exp %h", o, e); end
        tick();
        reset = 1'b0;
        #2;
        sb.push_back(mk(NOP, 0, 0, 4, 0, 0));
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL reset_released got %h exp %h", o, e); end
        n_cmp++;
        if (fif.imem_addr !== 9'h000) begin
            n_bad++; $display("FAIL reset_imem_addr got %h exp 000", fif.imem_addr);
        end
    endtask

    task automatic test_sequential();
        obs_t o, e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(mk(rom[i], 4*i, 4*(i+1), 4*(i+2), i+1, 1'b1));
            tick();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL seq[%0d] got %h exp %h", i, o, e); end
        end
        n_cmp++;
        if (fif.imem_addr !== 9'h010) begin
            n_bad++; $display("FAIL seq_imem_addr got %h exp 010", fif.imem_addr);
        end
    endtask

    task automatic test_le_freeze();
        obs_t o, e;
        do_reset();
        tick(); tick();
        fif.LE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // a branch pulse while frozen must be ignored
            fif.br_taken = (i == 1); fif.br_target = 32'h0000_0080;
            sb.push_back(mk(rom[1], 4, 8, 12, 2, 1'b1));
            tick();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL le_freeze[%0d] got %h exp %h", i, o, e); end
        end
        fif.br_taken = 1'b0; fif.LE = 1'b1;
        sb.push_back(mk(rom[2], 8, 12, 16, 3, 1'b1));
        tick();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL le_resume got %h exp %h", o, e); end
    endtask

    task automatic test_stall();
        obs_t o, e;
        do_reset();
        tick(); tick();
        fif.hz_stall = 1'b1;
        sb.push_back(mk(rom[1], 4, 8, 12, 2, 1'b1));
        tick();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL stall_hold got %h exp %h", o, e); end
        fif.hz_stall = 1'b0;
        sb.push_back(mk(rom[2], 8, 12, 16, 3, 1'b1));
        tick();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL stall_release got %h exp %h", o, e); end
    endtask

    task automatic test_branch();
        obs_t o, e;
        do_reset();
        tick(); tick(); tick();
        fif.br_taken = 1'b1; fif.br_target = 32'h0000_0040;
        sb.push_back(mk(NOP, 8, 32'h40, 32'h44, 3, 1'b0));
        tick();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL branch_squash got %h exp %h", o, e); end
        fif.br_taken = 1'b0;
        sb.push_back(mk(rom[16], 32'h40, 32'h44, 32'h48, 4, 1'b1));
        tick();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL branch_target_fetch got %h exp %h", o, e); end
    endtask

    task automatic test_branch_stall();
        obs_t o, e;
        do_reset();
        tick(); tick();
        fif.br_taken = 1'b1; fif.hz_stall = 1'b1; fif.br_target = 32'h0000_0043;
        sb.push_back(mk(rom[1], 4, 32'h40, 32'h44, 2, 1'b1));
        tick();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL branch_stall got %h exp %h", o, e); end
        fif.br_taken = 1'b0; fif.hz_stall = 1'b0;
        sb.push_back(mk(rom[16], 32'h40, 32'h44, 32'h48, 3, 1'b1));
        tick();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL branch_stall_next got %h exp %h", o, e); end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        do_reset();
        fif.br_taken = 1'b1; fif.br_target = 32'h0000_0040;
        tick();
        fif.br_taken = 1'b0;
        tick();
        n_cmp++;
        if (fif.PCFrontOut !== 32'h44) begin
            n_bad++; $display("FAIL async_pre got %h exp 00000044", fif.PCFrontOut);
        end
        #2;   // mid-cycle, well away from any edge
        reset = 1'b1;
        #1;
        sb.push_back(mk(NOP, 0, 0, 4, 0, 0));
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL async_reset got %h exp %h", o, e); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_wrap();
        obs_t o, e;
        do_reset();
        fif.br_taken = 1'b1; fif.br_target = 32'hFFFF_FFF8;
        sb.push_back(mk(NOP, 0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 0, 1'b0));
        tick();
        e = sb.pop_front(); o = observe(); n_cmp++;
        if (o !== e) begin n_bad++; $display("FAIL wrap_branch got %h exp %h", o, e); end
        n_cmp++;
        if (fif.imem_addr !== 9'h1F8) begin
            n_bad++; $display("FAIL wrap_imem_addr got %h exp 1f8", fif.imem_addr);
        end
        fif.br_taken = 1'b0;
        sb.push_back(mk(rom[126], 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 1, 1'b1));
        sb.push_back(mk(rom[127], 32'hFFFF_FFFC, 32'h0, 32'h4, 2, 1'b1));
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front(); o = observe(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL wrap_adv[%0d] got %h exp %h", i, o, e); end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 32'hC0DE_0000 | (i * 32'h101);
        test_reset();
        test_sequential();
        test_le_freeze();
        test_stall();
        test_branch();
        test_branch_stall();
        test_async_reset();
        test_wrap();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
